// File: rtl/lcd_pkg.sv
// Shared types, colour constants and bounce-step helper for the LCD block display.
package lcd_pkg;

    localparam int COORD_W = 11;

    typedef logic [COORD_W-1:0] coord_t;

    localparam logic [15:0] WHITE  = 16'hFFFF;
    localparam logic [15:0] BLACK  = 16'h0000;
    localparam logic [15:0] RED    = 16'hF800;
    localparam logic [15:0] GREEN  = 16'h07E0;
    localparam logic [15:0] BLUE   = 16'h001F;
    localparam logic [15:0] YELLOW = 16'hFFE0;

    typedef enum logic {
        DIR_DEC = 1'b0,
        DIR_INC = 1'b1
    } dir_t;

    typedef struct packed {
        coord_t pos;
        dir_t   dir;
    } axis_t;

    // One movement step on one axis. A position beyond the limit (after a
    // resolution shrink) is clamped and sent back toward 0; it never wraps.
    function automatic axis_t step_axis(input coord_t pos, input dir_t dir,
                                        input coord_t disp, input coord_t size,
                                        input coord_t step);
        coord_t             lim;
        logic [COORD_W:0]   fwd;
        axis_t              r;
        lim = (disp > size) ? coord_t'(disp - size) : '0;
        fwd = {1'b0, pos} + {1'b0, step};
        r   = '{pos: pos, dir: dir};
        if (pos > lim) begin
            r = '{pos: lim, dir: DIR_DEC};
        end else if (dir == DIR_INC) begin
            if (fwd >= {1'b0, lim}) r = '{pos: lim, dir: DIR_DEC};
            else                    r = '{pos: coord_t'(fwd), dir: DIR_INC};
        end else begin
            if (pos <= step) r = '{pos: '0, dir: DIR_INC};
            else             r = '{pos: coord_t'(pos - step), dir: DIR_DEC};
        end
        return r;
    endfunction

endpackage

// File: rtl/lcd_block_mover.sv
// Frame-end detection, frame divider and bouncing block position registers.
module lcd_block_mover
    import lcd_pkg::*;
#(
    parameter logic [10:0] BLOCK_SIZE = 11'd50,
    parameter logic [10:0] STEP       = 11'd2,
    parameter logic [7:0]  FRAME_DIV  = 8'd1
) (
    input  logic         lcd_pclk,
    input  logic         rst_n,
    input  logic [10:0]  pixel_xpos,
    input  logic [10:0]  pixel_ypos,
    input  logic [10:0]  h_disp,
    input  logic [10:0]  v_disp,
    output logic [10:0]  block_x,
    output logic [10:0]  block_y
);

    logic       frame_end;
    logic       move_tick;
    logic [7:0] div_cnt;
    dir_t       dir_x;
    dir_t       dir_y;
    axis_t      next_x;
    axis_t      next_y;

    // Last requested pixel of the frame; position only changes here, so no tearing.
    assign frame_end = (pixel_ypos == v_disp) && (pixel_xpos == coord_t'(h_disp - 11'd1));
    assign move_tick = frame_end && (div_cnt == FRAME_DIV - 8'd1);

    assign next_x = step_axis(block_x, dir_x, h_disp, BLOCK_SIZE, STEP);
    assign next_y = step_axis(block_y, dir_y, v_disp, BLOCK_SIZE, STEP);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= 8'd0;
            block_x <= '0;
            block_y <= '0;
            dir_x   <= DIR_INC;
            dir_y   <= DIR_INC;
        end else if (frame_end) begin
            if (move_tick) begin
                div_cnt <= 8'd0;
                block_x <= next_x.pos;
                dir_x   <= next_x.dir;
                block_y <= next_y.pos;
                dir_y   <= next_y.dir;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/lcd_block_display.sv
// Pixel source: five vertical colour bars with a bouncing square block on top.
module lcd_block_display
    import lcd_pkg::*;
#(
    parameter logic [10:0] BLOCK_SIZE  = 11'd50,
    parameter logic [10:0] STEP        = 11'd2,
    parameter logic [7:0]  FRAME_DIV   = 8'd1,
    parameter logic [15:0] BLOCK_COLOR = 16'hFFE0
) (
    input  logic         lcd_pclk,
    input  logic         rst_n,
    input  logic [10:0]  pixel_xpos,
    input  logic [10:0]  pixel_ypos,
    input  logic [10:0]  h_disp,
    input  logic [10:0]  v_disp,
    output logic [15:0]  pixel_data
);

    logic [10:0] block_x;
    logic [10:0] block_y;
    logic [10:0] row;
    logic [13:0] x5;
    logic [15:0] bar_color;
    logic        in_block;

    lcd_block_mover #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .STEP       (STEP),
        .FRAME_DIV  (FRAME_DIV)
    ) u_mover (
        .lcd_pclk   (lcd_pclk),
        .rst_n      (rst_n),
        .pixel_xpos (pixel_xpos),
        .pixel_ypos (pixel_ypos),
        .h_disp     (h_disp),
        .v_disp     (v_disp),
        .block_x    (block_x),
        .block_y    (block_y)
    );

    assign row = pixel_ypos - 11'd1;

    // Bar index from xpos*5 against multiples of h_disp; avoids a divider.
    assign x5 = 14'(pixel_xpos) * 14'd5;

    always_comb begin
        bar_color = BLUE;
        if      (x5 < 14'(h_disp))           bar_color = WHITE;
        else if (x5 < 14'(h_disp) * 14'd2)   bar_color = BLACK;
        else if (x5 < 14'(h_disp) * 14'd3)   bar_color = RED;
        else if (x5 < 14'(h_disp) * 14'd4)   bar_color = GREEN;
    end

    assign in_block = ({1'b0, pixel_xpos} >= {1'b0, block_x}) &&
                      ({1'b0, pixel_xpos} <  {1'b0, block_x} + {1'b0, BLOCK_SIZE}) &&
                      ({1'b0, row}        >= {1'b0, block_y}) &&
                      ({1'b0, row}        <  {1'b0, block_y} + {1'b0, BLOCK_SIZE});

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n)                  pixel_data <= 16'h0000;
        else if (pixel_ypos == '0)   pixel_data <= 16'h0000;
        else if (in_block)           pixel_data <= BLOCK_COLOR;
        else                         pixel_data <= bar_color;
    end

endmodule

// File: tb/tb_lcd_block_display.sv
// Directed self-checking bench for lcd_block_display (default and FRAME_DIV=3 instances).
module tb_lcd_block_display;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] xpos = '0;
    logic [10:0] ypos = '0;
    logic [10:0] h_disp = 11'd480;
    logic [10:0] v_disp = 11'd272;
    logic [15:0] pixel_data;
    logic [15:0] pixel_data3;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    lcd_block_display dut (
        .lcd_pclk   (clk),
        .rst_n      (rst_n),
        .pixel_xpos (xpos),
        .pixel_ypos (ypos),
        .h_disp     (h_disp),
        .v_disp     (v_disp),
        .pixel_data (pixel_data)
    );

    lcd_block_display #(.FRAME_DIV(8'd3)) dut3 (
        .lcd_pclk   (clk),
        .rst_n      (rst_n),
        .pixel_xpos (xpos),
        .pixel_ypos (ypos),
        .h_disp     (h_disp),
        .v_disp     (v_disp),
        .pixel_data (pixel_data3)
    );

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        xpos  = '0;
        ypos  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one request and return the registered pixel one cycle later.
    task automatic request(input logic [10:0] x, input logic [10:0] y, output logic [15:0] pd);
        @(negedge clk);
        xpos = x;
        ypos = y;
        @(posedge clk);
        #1 pd = pixel_data;
    endtask

    // Each frame collapses to its last requested pixel followed by an idle cycle.
    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            xpos = h_disp - 11'd1;
            ypos = v_disp;
            @(negedge clk);
            xpos = '0;
            ypos = '0;
        end
    endtask

    task automatic test_reset();
        logic [15:0] pd;
        request(11'd300, 11'd200, pd);
        total_cnt++;
        if (pd !== 16'h07E0) $display("FAIL pre_reset_green got=%h exp=07e0", pd);
        else pass_cnt++;
        @(negedge clk);
        xpos = 11'd100;
        ypos = 11'd50;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (pixel_data !== 16'h0000) $display("FAIL async_reset_pixel got=%h exp=0000", pixel_data);
        else pass_cnt++;
        total_cnt++;
        if (dut.block_x !== 11'd0 || dut.block_y !== 11'd0)
            $display("FAIL reset_block got=(%0d,%0d) exp=(0,0)", dut.block_x, dut.block_y);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        request(11'd0, 11'd1, pd);
        total_cnt++;
        if (pd !== 16'hFFE0) $display("FAIL first_pixel_block got=%h exp=ffe0", pd);
        else pass_cnt++;
    endtask

    task automatic test_bars();
        logic [10:0] xs [7] = '{11'd0, 11'd95, 11'd96, 11'd191, 11'd192, 11'd300, 11'd479};
        logic [15:0] es [7] = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'hF800, 16'h07E0, 16'h001F};
        logic [15:0] pd;
        for (int i = 0; i < 7; i++) begin
            request(xs[i], 11'd200, pd);
            total_cnt++;
            if (pd !== es[i]) $display("FAIL bar_x%0d got=%h exp=%h", xs[i], pd, es[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_block_edges();
        logic [10:0] xs [3] = '{11'd49, 11'd50, 11'd49};
        logic [10:0] ys [3] = '{11'd50, 11'd50, 11'd51};
        logic [15:0] es [3] = '{16'hFFE0, 16'hFFFF, 16'hFFFF};
        logic [15:0] pd;
        for (int i = 0; i < 3; i++) begin
            request(xs[i], ys[i], pd);
            total_cnt++;
            if (pd !== es[i]) $display("FAIL edge_x%0d_y%0d got=%h exp=%h", xs[i], ys[i], pd, es[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_divider();
        h_disp = 11'd480;
        v_disp = 11'd272;
        do_reset();
        run_frames(2);
        total_cnt++;
        if (dut3.block_x !== 11'd0) $display("FAIL div_2_frames got=%0d exp=0", dut3.block_x);
        else pass_cnt++;
        total_cnt++;
        if (dut.block_x !== 11'd4) $display("FAIL div1_2_frames got=%0d exp=4", dut.block_x);
        else pass_cnt++;
        repeat (10) @(negedge clk);
        total_cnt++;
        if (pixel_data3 !== 16'h0000 || dut3.block_x !== 11'd0)
            $display("FAIL idle_no_motion got=pd %h x %0d exp=pd 0000 x 0", pixel_data3, dut3.block_x);
        else pass_cnt++;
        run_frames(1);
        total_cnt++;
        if (dut3.block_x !== 11'd2 || dut3.block_y !== 11'd2)
            $display("FAIL div_3rd_frame got=(%0d,%0d) exp=(2,2)", dut3.block_x, dut3.block_y);
        else pass_cnt++;
        run_frames(2);
        total_cnt++;
        if (dut3.block_x !== 11'd2) $display("FAIL div_5_frames got=%0d exp=2", dut3.block_x);
        else pass_cnt++;
        run_frames(1);
        total_cnt++;
        if (dut3.block_x !== 11'd4) $display("FAIL div_6_frames got=%0d exp=4", dut3.block_x);
        else pass_cnt++;
    endtask

    task automatic test_bounce();
        h_disp = 11'd480;
        v_disp = 11'd272;
        do_reset();
        run_frames(111);
        total_cnt++;
        if (dut.block_y !== 11'd222 || dut.u_mover.dir_y !== 1'b0)
            $display("FAIL bounce_y_edge got=%0d/%0b exp=222/0", dut.block_y, dut.u_mover.dir_y);
        else pass_cnt++;
        run_frames(1);
        total_cnt++;
        if (dut.block_y !== 11'd220) $display("FAIL bounce_y_back got=%0d exp=220", dut.block_y);
        else pass_cnt++;
        run_frames(103);
        total_cnt++;
        if (dut.block_x !== 11'd430 || dut.u_mover.dir_x !== 1'b0)
            $display("FAIL bounce_x_edge got=%0d/%0b exp=430/0", dut.block_x, dut.u_mover.dir_x);
        else pass_cnt++;
        run_frames(1);
        total_cnt++;
        if (dut.block_x !== 11'd428 || dut.block_y !== 11'd12)
            $display("FAIL bounce_x_back got=(%0d,%0d) exp=(428,12)", dut.block_x, dut.block_y);
        else pass_cnt++;
        run_frames(214);
        total_cnt++;
        if (dut.block_x !== 11'd0 || dut.u_mover.dir_x !== 1'b1)
            $display("FAIL bounce_x_zero got=%0d/%0b exp=0/1", dut.block_x, dut.u_mover.dir_x);
        else pass_cnt++;
        run_frames(1);
        total_cnt++;
        if (dut.block_x !== 11'd2) $display("FAIL bounce_x_restart got=%0d exp=2", dut.block_x);
        else pass_cnt++;
    endtask

    task automatic test_shrink();
        logic overflow;
        h_disp = 11'd800;
        v_disp = 11'd480;
        do_reset();
        run_frames(350);
        total_cnt++;
        if (dut.block_x !== 11'd700 || dut.block_y !== 11'd160)
            $display("FAIL shrink_pre got=(%0d,%0d) exp=(700,160)", dut.block_x, dut.block_y);
        else pass_cnt++;
        @(negedge clk);
        h_disp = 11'd480;
        v_disp = 11'd272;
        run_frames(1);
        total_cnt++;
        if (dut.block_x !== 11'd430 || dut.u_mover.dir_x !== 1'b0 || dut.block_y !== 11'd158)
            $display("FAIL shrink_clamp got=%0d/%0b y=%0d exp=430/0 y=158",
                     dut.block_x, dut.u_mover.dir_x, dut.block_y);
        else pass_cnt++;
        overflow = 1'b0;
        for (int i = 0; i < 500; i++) begin
            run_frames(1);
            if (dut.block_x > 11'd430 || dut.block_y > 11'd222) overflow = 1'b1;
        end
        total_cnt++;
        if (overflow !== 1'b0) $display("FAIL shrink_no_wrap got=%0b exp=0", overflow);
        else pass_cnt++;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_bars();
        test_block_edges();
        test_divider();
        test_bounce();
        test_shrink();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/lcd_block_display.md
Name: lcd_block_display

Overview:
- Pixel source that sits directly upstream of the RGB LCD timing driver.
- Takes the driver's requested pixel coordinates and active resolution, and returns one RGB565 word per request.
- Draws five vertical colour bars as the background, with a square block on top that bounces off the screen edges.
- The block moves once every FRAME_DIV frames; the display stays resolution-agnostic across all supported panels.

Parameters:
- BLOCK_SIZE, 11'd50, block edge length in pixels.
- STEP, 11'd2, pixels moved per axis per movement tick.
- FRAME_DIV, 8'd1, frames per movement tick (1 = move every frame).
- BLOCK_COLOR, 16'hFFE0, RGB565 block colour (yellow).

Ports:
- lcd_pclk  input  1  pixel clock, same clock as the driver.
- rst_n  input  1  asynchronous active-low reset.
- pixel_xpos  input  11  requested column; 0..h_disp-1 during a request, 0 otherwise.
- pixel_ypos  input  11  requested row plus one; 1..v_disp during a request, 0 otherwise.
- h_disp  input  11  active horizontal resolution.
- v_disp  input  11  active vertical resolution.
- pixel_data  output  16  RGB565 pixel, registered.

Behaviour:
- Clocking and reset:
  - Single clock domain, lcd_pclk.
  - All state is cleared by the asynchronous rst_n.
  - Reset values: pixel_data = 0, block_x = 0, block_y = 0, dir_x = right, dir_y = down, div_cnt = 0.
- Latency and coordinates:
  - pixel_data is registered with exactly 1 cycle latency. The driver requests one cycle ahead of DE, so this aligns with DE.
  - row = pixel_ypos - 1.
  - pixel_ypos == 0 means no request: pixel_data <= 16'h0000.
- Background bars: bar k is selected by h_disp*k <= pixel_xpos*5 < h_disp*(k+1). Use constant multiplies only; no dividers.
  - k=0 white FFFF
  - k=1 black 0000
  - k=2 red F800
  - k=3 green 07E0
  - k=4 blue 001F
- Block overlay: output BLOCK_COLOR when both of the following hold; the overlay has priority over the bars.
  - block_x <= pixel_xpos < block_x + BLOCK_SIZE
  - block_y <= row < block_y + BLOCK_SIZE
- Frame tick:
  - frame_end is a one-cycle pulse, asserted when pixel_ypos == v_disp and pixel_xpos == h_disp-1 (last requested pixel of the frame).
  - div_cnt counts frame_end pulses. When div_cnt == FRAME_DIV-1 it wraps to 0 and issues move_tick.
- Movement on move_tick, X axis (Y is identical, using v_disp, block_y and dir_y):
  - lim = h_disp - BLOCK_SIZE.
  - Moving right: if block_x + STEP >= lim, set block_x <= lim and dir_x <= left. Otherwise block_x <= block_x + STEP.
  - Moving left: if block_x <= STEP, set block_x <= 0 and dir_x <= right. Otherwise block_x <= block_x - STEP.
  - The edge pixel is always reached exactly; the direction flips on the same tick the edge is reached.
- Resolution change:
  - If h_disp or v_disp shrinks so that block_x > lim (or block_y > its Y limit), the next move_tick clamps the coordinate to lim and sets the direction toward 0.
  - The position never wraps.
- Coordinate updates happen only at frame_end, so the block is never torn mid-frame.
- Width rules: all coordinate arithmetic is 11 bits; the bar comparisons use 14-bit products. The position and direction registers must not underflow.

Decomposition:
- Shared package lcd_pkg holds:
  - the RGB565 colour constants: WHITE, BLACK, RED, GREEN, BLUE, YELLOW;
  - the 11-bit coordinate width constant;
  - the direction encoding (1 = increasing).
- One sub-module, lcd_block_mover, contains:
  - the frame-end detection and frame divider;
  - the block_x/block_y registers and the bounce logic;
  - outputs block_x and block_y.
- The top level keeps the bar select, overlay compare and output register.

Test Plan:
- Reset mid-frame: assert rst_n low while xpos=100, ypos=50. Expect pixel_data=0 immediately (async), block at (0,0). Release reset; xpos=0, ypos=1 at 480x272 -> one cycle later pixel_data=FFE0.
- Bars at 480x272, ypos=200 (outside block): xpos 0, 95, 96, 191, 192, 300, 479 -> one cycle later FFFF, FFFF, 0000, 0000, F800, 07E0, 001F.
- Block edges with block at (0,0): xpos 49, ypos 50 -> FFE0; xpos 50, ypos 50 -> FFFF; xpos 49, ypos 51 -> FFFF.
- Bounce at 480x272, STEP=2, FRAME_DIV=1, run frames. block_x=0,2,... reaches 430 and the next tick gives 428 (dir left). block_y reaches 222 and turns. After returning, block_x reaches 0 and dir flips to right.
- Divider with FRAME_DIV=3: block moves only on every 3rd frame_end. ypos=0 idle cycles produce pixel_data=0 and no motion.
- Resolution shrink: block at x=700 with 800x480 active, then switch to 480x272. The next move_tick gives block_x=430 and dir left; no wraparound ever appears.
